// File: rtl/mem_store_buffer.sv
// In-order store buffer between the EX/MEM pipeline register and data memory.
// Latency: a retired store reaches the memory port no earlier than the next cycle; loads pass through combinationally.
// Backpressure: o_stall holds the pipeline on a load/store address conflict, a store into a full buffer, or a fence with entries pending.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_memAddr, i_writeData    byte address and store data from EX/MEM
//   i_ctrlMEM[4:0]            {memRead, memWrite, size[1:0], sign} from EX/MEM
//   i_drainReq                fence/ecall: hold the pipeline until the buffer is empty
//   o_memAddr, o_writeData    data memory address / write data
//   o_ctrlMEM[4:0]            {memRead, memWrite, size[1:0], sign} to data memory
//   o_stall, o_empty          pipeline hold, buffer empty
//   o_stallCycles, o_storesDrained   saturating statistics (only when SB_STATS_EN is defined)
//
// Optional feature macro: SB_STATS_EN adds the two statistics counters and their ports.
module mem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_memAddr,
    input  logic [31:0] i_writeData,
    input  logic [4:0]  i_ctrlMEM,
    input  logic        i_drainReq,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_writeData,
    output logic [4:0]  o_ctrlMEM,
    output logic        o_stall,
    output logic        o_empty
`ifdef SB_STATS_EN
    ,
    output logic [31:0] o_stallCycles,
    output logic [31:0] o_storesDrained
`endif
);

    localparam int             PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]    C_FULL = (PW + 1)'(DEPTH);

    // Entry storage and queue pointers
    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [1:0]    r_size [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic             w_load;
    logic             w_store;
    logic             w_full;
    logic             w_nonEmpty;
    logic [DEPTH-1:0] w_hit;
    logic             w_conflict;
    logic             w_issueLoad;
    logic             w_drain;
    logic             w_enq;

    // A request with both memRead and memWrite set is handled as a load.
    assign w_load     = i_ctrlMEM[4];
    assign w_store    = i_ctrlMEM[3] & ~i_ctrlMEM[4];
    assign w_full     = (r_count == C_FULL);
    assign w_nonEmpty = (r_count != '0);

    // An entry is live when its distance from head (mod DEPTH) is below count;
    // only live entries can cause a word-address conflict.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit[i] = ({1'b0, PW'(i) - r_head} < r_count) &&
                       (r_addr[i][31:2] == i_memAddr[31:2]);
        end
    end

    assign w_conflict  = w_load & (|w_hit);
    assign w_issueLoad = w_load & ~w_conflict;
    assign w_drain     = ~w_issueLoad & w_nonEmpty;

    assign o_stall = w_conflict | (w_store & w_full) | (i_drainReq & w_nonEmpty);
    assign o_empty = ~w_nonEmpty;

    // A stalled store is presented again next cycle, so it is only captured
    // in a cycle that the pipeline actually advances.
    assign w_enq = w_store & ~w_full & ~o_stall;

    // Memory port mux: a non-conflicting load owns the port, otherwise the head drains.
    always_comb begin
        o_memAddr   = '0;
        o_writeData = '0;
        o_ctrlMEM   = '0;
        if (!i_reset_n) begin
            o_ctrlMEM = '0;
        end else if (w_issueLoad) begin
            o_memAddr = i_memAddr;
            o_ctrlMEM = {1'b1, 1'b0, i_ctrlMEM[2:0]};
        end else if (w_drain) begin
            o_memAddr   = r_addr[r_head];
            o_writeData = r_data[r_head];
            o_ctrlMEM   = {1'b0, 1'b1, r_size[r_head], 1'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: validity is defined entirely by head/count.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= i_memAddr;
            r_data[r_tail] <= i_writeData;
            r_size[r_tail] <= i_ctrlMEM[2:1];
        end
    end

`ifdef SB_STATS_EN
    logic [31:0] r_stallCycles;
    logic [31:0] r_storesDrained;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stallCycles   <= '0;
            r_storesDrained <= '0;
        end else begin
            if (o_stall && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (w_drain && (r_storesDrained != '1)) begin
                r_storesDrained <= r_storesDrained + 1'b1;
            end
        end
    end

    assign o_stallCycles   = r_stallCycles;
    assign o_storesDrained = r_storesDrained;
`endif

`ifndef SYNTHESIS
    a_noReadWrite: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(i_ctrlMEM[4] && i_ctrlMEM[3]));
`endif

endmodule

// File: tb/tb_mem_store_buffer.sv
// Testbench for mem_store_buffer: directed scenarios plus randomized traffic against a queue model.
// Inputs change 1 time unit after posedge; outputs are checked 1 time unit later.
// The bench honours o_stall by re-presenting the same request until the model says it advances.
module tb_mem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_memAddr;
    logic [31:0] i_writeData;
    logic [4:0]  i_ctrlMEM;
    logic        i_drainReq;
    logic [31:0] o_memAddr;
    logic [31:0] o_writeData;
    logic [4:0]  o_ctrlMEM;
    logic        o_stall;
    logic        o_empty;
`ifdef SB_STATS_EN
    logic [31:0] o_stallCycles;
    logic [31:0] o_storesDrained;
`endif

    always #5 clk = ~clk;

    mem_store_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset_n   (i_reset_n),
        .i_memAddr   (i_memAddr),
        .i_writeData (i_writeData),
        .i_ctrlMEM   (i_ctrlMEM),
        .i_drainReq  (i_drainReq),
        .o_memAddr   (o_memAddr),
        .o_writeData (o_writeData),
        .o_ctrlMEM   (o_ctrlMEM),
        .o_stall     (o_stall),
        .o_empty     (o_empty)
`ifdef SB_STATS_EN
        ,
        .o_stallCycles   (o_stallCycles),
        .o_storesDrained (o_storesDrained)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } ent_t;

    ent_t        q[$];        // model: pending stores, oldest first
    logic [63:0] exp_wr[$];   // model: memory writes in order {addr,data}
    logic [63:0] dut_wr[$];   // observed memory writes
    int          m_stalls;
    int          m_drains;
    logic        last_dut_stall;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] size, input logic sgn,
                        input logic drn, output logic stalled);
        logic        conflict;
        logic        store;
        logic        issue_ld;
        logic [4:0]  ectrl;
        logic [31:0] eaddr;
        logic [31:0] edata;
        int          cnt;
        ent_t        e;
        i_memAddr   = addr;
        i_writeData = data;
        i_ctrlMEM   = {rd, wr, size, sgn};
        i_drainReq  = drn;
        #1;
        store    = wr && !rd;
        cnt      = q.size();
        conflict = 1'b0;
        if (rd) begin
            foreach (q[i]) if (q[i].addr[31:2] == addr[31:2]) conflict = 1'b1;
        end
        stalled  = conflict || (store && cnt == DEPTH) || (drn && cnt > 0);
        issue_ld = rd && !conflict;
        ectrl = '0; eaddr = '0; edata = '0;
        if (issue_ld) begin
            ectrl = {1'b1, 1'b0, size, sgn};
            eaddr = addr;
        end else if (cnt > 0) begin
            ectrl = {1'b0, 1'b1, q[0].size, 1'b0};
            eaddr = q[0].addr;
            edata = q[0].data;
        end
        chk("stall", 32'(o_stall), 32'(stalled));
        chk("empty", 32'(o_empty), 32'(cnt == 0));
        chk("ctrl",  32'(o_ctrlMEM), 32'(ectrl));
        chk("addr",  o_memAddr, eaddr);
        chk("wdata", o_writeData, edata);
        last_dut_stall = o_stall;
        if (o_ctrlMEM[3]) dut_wr.push_back({o_memAddr, o_writeData});
        if (stalled) m_stalls++;
        if (!issue_ld && cnt > 0) begin
            exp_wr.push_back({q[0].addr, q[0].data});
            void'(q.pop_front());
            m_drains++;
        end
        if (store && !stalled && cnt < DEPTH) begin
            e.addr = addr; e.data = data; e.size = size;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it while stalled, as the pipeline would.
    task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] size, input logic sgn,
                      input logic drn);
        logic st;
        int   n;
        n  = 0;
        st = 1'b1;
        while (st && n < 16) begin
            step(rd, wr, addr, data, size, sgn, drn, st);
            n++;
        end
        if (st) chk("hold_bound", 32'd1, 32'd0);
    endtask

    task automatic nop();
        op(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        m_stalls = 0;
        m_drains = 0;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        i_reset_n   = 1'b0;
        i_memAddr   = '0;
        i_writeData = '0;
        i_ctrlMEM   = '0;
        i_drainReq  = 1'b0;
        model_reset();
        #1;
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_ctrl",  32'(o_ctrlMEM), 32'd0);
        chk("rst_addr",  o_memAddr, 32'd0);
        chk("rst_wdata", o_writeData, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        i_reset_n = 1'b1;

        // Load hitting a pending store's word (first, so statistics start from reset)
        op(1'b0, 1'b1, 32'h200, 32'h1111_2222, 2'b10, 1'b0, 1'b0);
        op(1'b1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("conf_stalls", 32'(m_stalls), 32'd1);
`ifdef SB_STATS_EN
        chk("stat_stalls", o_stallCycles, 32'(m_stalls));
        chk("stat_drains", o_storesDrained, 32'd1);
`endif

        // Store into empty buffer, write appears the following cycle
        op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0);
        chk("sw100_stall", 32'(last_dut_stall), 32'd0);
        nop();
        chk("sw100_addr", dut_wr[dut_wr.size()-1][63:32], 32'h100);
        chk("sw100_data", dut_wr[dut_wr.size()-1][31:0], 32'hDEADBEEF);

        // Five back-to-back stores then a fence
        dut_wr.delete();
        exp_wr.delete();
        for (int i = 1; i <= 5; i++) begin
            op(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'(i), 2'b10, 1'b0, 1'b0);
            chk("sw5_nostall", 32'(last_dut_stall), 32'd0);
        end
        op(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
        chk("fence_empty", 32'(o_empty), 32'd1);
        chk("order_n", 32'(dut_wr.size()), 32'd5);
        for (int i = 0; i < dut_wr.size() && i < 5; i++) begin
            chk("order", dut_wr[i][31:0], 32'(i + 1));
        end

        // Non-conflicting load takes the port, drain pauses
        op(1'b0, 1'b1, 32'h300, 32'hA5A5_0300, 2'b10, 1'b0, 1'b0);
        op(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("ld400_stall", 32'(last_dut_stall), 32'd0);
        chk("ld400_pending", 32'(o_empty), 32'd0);
        nop();

        // Reset while an entry is draining
        op(1'b0, 1'b1, 32'h700, 32'h0000_0700, 2'b10, 1'b0, 1'b0);
        i_memAddr = '0; i_writeData = '0; i_ctrlMEM = '0; i_drainReq = 1'b0;
        i_reset_n = 1'b0;
        #1;
        chk("midrst_empty", 32'(o_empty), 32'd1);
        chk("midrst_ctrl",  32'(o_ctrlMEM), 32'd0);
        chk("midrst_stall", 32'(o_stall), 32'd0);
        model_reset();
        @(posedge clk); #1;
        i_reset_n = 1'b1;
        dut_wr.delete();
        exp_wr.delete();
        repeat (3) nop();
        chk("post_rst_writes", 32'(dut_wr.size()), 32'd0);

        // Randomized traffic over a small address window to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            a = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            if (r <= 4)      op(1'b0, 1'b1, a, $urandom, 2'($urandom_range(0, 2)), 1'b0, 1'b0);
            else if (r <= 7) op(1'b1, 1'b0, a, 32'h0, 2'($urandom_range(0, 2)), 1'($urandom), 1'b0);
            else if (r == 8) nop();
            else             op(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
        end
        op(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1);
        chk("rand_empty", 32'(o_empty), 32'd1);
        chk("rand_wr_n", 32'(dut_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < dut_wr.size() && i < exp_wr.size(); i++) begin
            if (dut_wr[i] !== exp_wr[i]) begin
                chk("rand_wr_addr", dut_wr[i][63:32], exp_wr[i][63:32]);
                chk("rand_wr_data", dut_wr[i][31:0], exp_wr[i][31:0]);
            end
        end
`ifdef SB_STATS_EN
        chk("rand_stat_stalls", o_stallCycles, 32'(m_stalls));
        chk("rand_stat_drains", o_storesDrained, 32'(m_drains));
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
